wsum_pipe: RTL and testbench
============================

# wsum_pipe

Parametrised, pipelined weighted-sum engine: N_IN unsigned samples are each scaled by a per-input weight code (+1, +2, −1, −2) and reduced through a registered binary adder tree to one signed result. It is the general successor of the fixed 16-input first-stage adder. It adds true two's-complement negation, a −2 weight, arbitrary input count, a valid/ready handshake with backpressure, and an optional multi-beat accumulator. It sits between the sample-gathering front end and the second-stage operator.

## Interface
- N_IN, 16: number of inputs, ≥2, need not be a power of two.
- DW, 8: unsigned input sample width.
- ACC_W, 24: accumulator/output width when WSUM_ACC_EN is defined, ≥OW.
- Derived: L = clog2(N_IN); OW = DW+2+L (signed tree output); LAT = L+1.
- clock  in  1  rising-edge clock; one clock domain. Reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset, sampled on the rising edge of clock.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  N_IN*DW  packed samples; sample i is in_data[i*DW +: DW].
- in_ctrl  in  N_IN*2  packed weight codes; code i is in_ctrl[i*2 +: 2].
- in_last  in  1  last beat of an accumulation group; present only with WSUM_ACC_EN.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  OW (ACC_W with WSUM_ACC_EN)  signed result.

## Operation
- Weight codes: 00 → +x, 01 → +2x, 10 → −x (two's complement, not bit inversion), 11 → −2x. Each term is sign-extended to DW+2 bits.
- Stage 0 registers the N_IN weighted terms. Levels 1..L each add adjacent pairs, grow the width by 1 bit and register the result. Missing pairs (non-power-of-two N_IN) are padded with zero.
- A valid bit travels with each stage, so bubbles propagate as invalid.
- Global advance: en = !out_valid || out_ready, and in_ready = en. All stage registers, including their valid bits, update only when en is high.
- A beat is accepted when in_valid && in_ready. out_data is stable while out_valid && !out_ready.
- Arithmetic is exact: |sum| ≤ N_IN·2·(2^DW−1) always fits in OW signed bits, so the tree never overflows.
- Reset clears all valid bits, all data registers, out_data (0) and the accumulator (0). Beats in flight at reset are dropped, and out_valid is 0 in the cycle after reset is sampled.
- in_valid with in_ready low has no effect; the upstream holds the beat.

## Timing
- Latency: a beat accepted at edge k produces out_valid at edge k+LAT when there is no stall. The default LAT is 5.
- Throughput: one beat per cycle while out_ready is held high.
- Stall: with out_valid=1 and out_ready=0, in_ready drops combinationally in the same cycle and the whole pipe freezes.
- Stall release: when out_ready returns high, the held result is consumed at that edge and the pipe advances by one stage.
- in_ready depends combinationally on out_ready. The path from in_valid to out_valid is fully registered.

## Configuration
- WSUM_ACC_EN not defined:
  - Every accepted beat yields exactly one OW-bit result.
  - in_last does not exist.
- WSUM_ACC_EN defined:
  - An in_last tag travels down the pipe alongside each beat.
  - When a beat leaves level L: if it is not last, its sign-extended sum is added into an ACC_W-bit accumulator and out_valid stays 0.
  - If the beat is last, out_data = acc + sum, out_valid = 1, and the accumulator clears to 0 in the same edge.
  - Accumulation wraps modulo 2^ACC_W.
  - Reset mid-group discards the partial sum.

## Structure
- Package wsum_pkg holds:
  - weight-code constants W_POS, W_POS2, W_NEG, W_NEG2;
  - a clog2 constant function;
  - width-derivation localparams for OW and LAT.
- Sub-module w_term (combinational): DW-bit sample plus 2-bit code in, signed DW+2-bit term out. It is instantiated N_IN times by a generate loop.
- The adder tree is built with nested generate loops in wsum_pipe itself.

## Test plan
- N_IN=16, DW=8, all codes 00, all samples 1, out_ready=1 → out_data=16, with out_valid exactly 5 cycles after acceptance.
- All samples 255, all codes 01 → 8160. All samples 255, all codes 11 → −8160 (14'h2020).
- Sample0=100 with code 10, sample1=50 with code 01, all other samples 0 → 0. Sample0=3 with code 10, all others 0 → −3 (true negate, not −4).
- Eight back-to-back beats with sums 1..8, out_ready low for 3 cycles mid-stream:
  - in_ready is low exactly while out_valid && !out_ready;
  - out_data is held during the stall;
  - outputs are 1..8 in order with none lost or duplicated.
- Three beats in flight, then reset high for one cycle → out_valid=0 and out_data=0 next cycle, and no stale results afterwards.
- WSUM_ACC_EN: three beats each summing 16, in_last on the third → a single output 48. The next group starts from 0.

Source files
------------

// File: rtl/wsum_pkg.sv
// rtl/wsum_pkg.sv - weight codes and width helpers for the wsum_pipe weighted-sum engine
package wsum_pkg;

  localparam logic [1:0] W_POS  = 2'b00;
  localparam logic [1:0] W_POS2 = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b10;
  localparam logic [1:0] W_NEG2 = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ow_width(input int n_in, input int dw);
    return dw + 2 + clog2(n_in);
  endfunction

  function automatic int lat_cycles(input int n_in);
    return clog2(n_in) + 1;
  endfunction

  localparam int DEF_N_IN = 16;
  localparam int DEF_DW   = 8;
  localparam int DEF_OW   = ow_width(DEF_N_IN, DEF_DW);
  localparam int DEF_LAT  = lat_cycles(DEF_N_IN);

endpackage

// File: rtl/wsum_pipe_w_term.sv
// rtl/wsum_pipe_w_term.sv - one weighted term: unsigned sample scaled by +1, +2, -1 or -2
module w_term
  import wsum_pkg::*;
#(
  parameter int DW = 8
)(
  input  logic [DW-1:0]        sample,
  input  logic [1:0]           code,
  output logic signed [DW+1:0] term
);

  logic signed [DW+1:0] x;

  // Two guard bits keep 2*x and its true negation representable.
  assign x = signed'({2'b00, sample});

  always_comb begin
    term = x;
    case (code)
      W_POS:  term = x;
      W_POS2: term = x <<< 1;
      W_NEG:  term = -x;
      W_NEG2: term = -(x <<< 1);
    endcase
  end

endmodule

// File: rtl/wsum_pipe.sv
// rtl/wsum_pipe.sv - pipelined weighted-sum adder tree with valid/ready; WSUM_ACC_EN adds a multi-beat accumulator
module wsum_pipe
  import wsum_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int DW    = 8,
  parameter int ACC_W = 24
)(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*DW-1:0]   in_data,
  input  logic [N_IN*2-1:0]    in_ctrl,
`ifdef WSUM_ACC_EN
  input  logic                 in_last,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef WSUM_ACC_EN
  output logic signed [ACC_W-1:0] out_data
`else
  output logic signed [ow_width(N_IN, DW)-1:0] out_data
`endif
);

  localparam int L    = clog2(N_IN);
  localparam int TW   = DW + 2;
  localparam int OW   = TW + L;
  localparam int NP   = 1 << L;
  localparam int ROOT = 2*NP - 2;

  logic                 en;
  logic signed [TW-1:0] term [N_IN];
  // Flattened tree: level lv occupies NP>>lv slots starting at 2*NP - 2*(NP>>lv).
  logic signed [OW-1:0] node [2*NP-1];
  logic [L:0]           vld;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar i = 0; i < N_IN; i++) begin : g_term
    w_term #(.DW(DW)) u_term (
      .sample (in_data[i*DW +: DW]),
      .code   (in_ctrl[i*2 +: 2]),
      .term   (term[i])
    );
  end

  for (genvar j = 0; j < NP; j++) begin : g_leaf
    if (j < N_IN) begin : g_real
      always_ff @(posedge clock)
        if (reset)   node[j] <= '0;
        else if (en) node[j] <= OW'(term[j]);
    end else begin : g_pad
      always_ff @(posedge clock)
        node[j] <= '0;
    end
  end

  for (genvar lv = 1; lv <= L; lv++) begin : g_lvl
    for (genvar j = 0; j < (NP >> lv); j++) begin : g_add
      localparam int DST = 2*NP - 2*(NP >> lv) + j;
      localparam int SRC = 2*NP - 2*(NP >> (lv-1)) + 2*j;
      always_ff @(posedge clock)
        if (reset)   node[DST] <= '0;
        else if (en) node[DST] <= node[SRC] + node[SRC+1];
    end
  end

  always_ff @(posedge clock)
    if (reset)   vld <= '0;
    else if (en) vld <= {vld[L-1:0], in_valid};

`ifdef WSUM_ACC_EN
  logic [L:0]              lst;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] root_ext;

  assign root_ext = ACC_W'(node[ROOT]);

  always_ff @(posedge clock)
    if (reset)   lst <= '0;
    else if (en) lst <= {lst[L-1:0], in_last};

  always_ff @(posedge clock)
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
    end else if (en) begin
      out_valid <= vld[L] && lst[L];
      if (vld[L]) begin
        if (lst[L]) begin
          out_data <= acc + root_ext;
          acc      <= '0;
        end else begin
          acc      <= acc + root_ext;
        end
      end
    end
`else
  always_ff @(posedge clock)
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= vld[L];
      if (vld[L]) out_data <= node[ROOT];
    end
`endif

endmodule

// File: tb/tb_wsum_pipe.sv
// tb/tb_wsum_pipe.sv - directed vector bench for wsum_pipe (covers WSUM_ACC_EN when defined)
module tb_wsum_pipe;

  localparam int N_IN = 16;
  localparam int DW   = 8;
`ifdef WSUM_ACC_EN
  localparam int OUT_W = 24;
`else
  localparam int OUT_W = 14;
`endif

  typedef struct {
    logic [N_IN*DW-1:0] data;
    logic [N_IN*2-1:0]  ctrl;
    int                 exp;
  } vec_t;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN*DW-1:0]      in_data;
  logic [N_IN*2-1:0]       in_ctrl;
`ifdef WSUM_ACC_EN
  logic                    in_last;
`endif
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  wsum_pipe #(.N_IN(N_IN), .DW(DW), .ACC_W(24)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
`ifdef WSUM_ACC_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N_IN*DW-1:0] rep_d(input logic [DW-1:0] s);
    return {N_IN{s}};
  endfunction

  function automatic logic [N_IN*2-1:0] rep_c(input logic [1:0] c);
    return {N_IN{c}};
  endfunction

  vec_t vecs[8];

  initial begin
    int lat, sent, rcv, cyc, extra, nout;
    logic acc_now, cons;
    logic [N_IN*DW-1:0] d;
    logic [N_IN*2-1:0]  c;
    logic signed [OUT_W-1:0] got;

    vecs[0] = '{rep_d(8'd1),   rep_c(2'b00), 16};
    vecs[1] = '{rep_d(8'd255), rep_c(2'b01), 8160};
    vecs[2] = '{rep_d(8'd255), rep_c(2'b11), -8160};
    vecs[3] = '{{112'd0, 8'd50, 8'd100}, {28'd0, 2'b01, 2'b10}, 0};
    vecs[4] = '{{120'd0, 8'd3}, {30'd0, 2'b10}, -3};
    vecs[5] = '{rep_d(8'd255), rep_c(2'b00), 4080};
    vecs[6] = '{rep_d(8'd255), rep_c(2'b10), -4080};
    for (int i = 0; i < N_IN; i++) begin
      d[i*DW +: DW] = 8'(i);
      c[i*2 +: 2]   = (i % 2 == 1) ? 2'b11 : 2'b01;
    end
    vecs[7] = '{d, c, -16};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_ctrl = '0;
`ifdef WSUM_ACC_EN
    in_last = 1'b1;
`endif
    repeat (2) step();
    reset = 1'b0;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset in_ready", in_ready, 1);

    // Single beats: latency and value
    for (int v = 0; v < 8; v++) begin
      in_data = vecs[v].data; in_ctrl = vecs[v].ctrl; in_valid = 1'b1;
      step();
      in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        step();
        lat++;
      end
      check($sformatf("vec%0d latency", v), lat, 5);
      check($sformatf("vec%0d data", v), out_data, vecs[v].exp);
    end
    repeat (3) step();

    // Streaming 1..8 with a 3-cycle consumer stall
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 8 && cyc < 60) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (sent < 8);
      in_data   = {120'd0, 8'(sent + 1)};
      in_ctrl   = '0;
      #1;
      check($sformatf("stream in_ready cyc%0d", cyc), in_ready, !(cyc >= 6 && cyc <= 8));
      if (out_valid) check($sformatf("stream data cyc%0d", cyc), out_data, rcv + 1);
      acc_now = in_valid && in_ready;
      cons    = out_valid && out_ready;
      step();
      if (acc_now) sent++;
      if (cons) rcv++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream received", rcv, 8);
    check("stream sent", sent, 8);
    extra = 0;
    repeat (8) begin
      step();
      if (out_valid) extra++;
    end
    check("stream extra outputs", extra, 0);

    // Reset with three beats in flight
    in_data = rep_d(8'd1); in_ctrl = '0; in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst out_valid", out_valid, 0);
    check("midrst out_data", out_data, 0);
    extra = 0;
    repeat (10) begin
      step();
      if (out_valid) extra++;
    end
    check("midrst stale outputs", extra, 0);

`ifdef WSUM_ACC_EN
    // Three-beat group then a single-beat group
    in_data = rep_d(8'd1); in_ctrl = '0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1; in_last = (b == 2);
      step();
    end
    in_valid = 1'b0; in_last = 1'b1;
    nout = 0; got = '0;
    repeat (12) begin
      if (out_valid) begin nout++; got = out_data; end
      step();
    end
    check("acc group1 count", nout, 1);
    check("acc group1 sum", got, 48);
    in_data = rep_d(8'd255); in_valid = 1'b1; in_last = 1'b1;
    step();
    in_valid = 1'b0;
    nout = 0; got = '0;
    repeat (12) begin
      if (out_valid) begin nout++; got = out_data; end
      step();
    end
    check("acc group2 count", nout, 1);
    check("acc group2 sum", got, 4080);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
